// File: rtl/elevator_motion_ctrl_if.sv
// Request/status bundle between the floor-request queue side and the car
// motion controller. The controller uses the slave view.
interface elevator_motion_ctrl_if;
  logic [3:0] head_floor;
  logic       door_hold;
  logic       queue_shift;
  logic [3:0] current_floor;
  logic [3:0] target_floor;
  logic       moving_up;
  logic       moving_down;
  logic       door_open;
  logic       busy;
  logic       req_error;

  modport master (
    output head_floor,
    output door_hold,
    input  queue_shift,
    input  current_floor,
    input  target_floor,
    input  moving_up,
    input  moving_down,
    input  door_open,
    input  busy,
    input  req_error
  );

  modport slave (
    input  head_floor,
    input  door_hold,
    output queue_shift,
    output current_floor,
    output target_floor,
    output moving_up,
    output moving_down,
    output door_open,
    output busy,
    output req_error
  );
endinterface

// File: rtl/elevator_motion_ctrl.sv
// Car motion controller fed by the head of the floor-request queue: travels one
// floor at a time to the head floor, holds the door, then pops the served entry.
module elevator_motion_ctrl #(
  parameter int MAX_FLOOR     = 15,
  parameter int HOME_FLOOR    = 1,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 16
) (
  input logic                  clk,
  input logic                  reset,
  elevator_motion_ctrl_if.slave bus
);

  localparam int CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MOVE_UP   = 3'd1,
    ST_MOVE_DOWN = 3'd2,
    ST_DOOR      = 3'd3,
    ST_POP       = 3'd4,
    ST_SETTLE    = 3'd5
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       cur_q;
  logic [3:0]       tgt_q;
  logic             up_q;
  logic             down_q;
  logic             door_q;
  logic             busy_q;
  logic             shift_q;
  logic             err_q;

  logic [3:0]       next_floor_d;
  logic [CNT_W-1:0] cnt_inc_d;
  logic             travel_done;
  logic             door_done;
  logic             head_empty;
  logic             head_invalid;

  // Terminal counts, the floor reached by the current step, and head classification.
  always_comb begin
    travel_done  = (cnt_q == CNT_W'(TRAVEL_CYCLES - 1));
    door_done    = (cnt_q == CNT_W'(DOOR_CYCLES - 1));
    cnt_inc_d    = cnt_q + CNT_W'(1);
    head_empty   = (bus.head_floor == 4'd0);
    head_invalid = (bus.head_floor > 4'(MAX_FLOOR));
    if (state_q == ST_MOVE_DOWN) begin
      next_floor_d = cur_q - 4'd1;
    end else begin
      next_floor_d = cur_q + 4'd1;
    end
  end

  // Trip sequencer; every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cur_q   <= 4'(HOME_FLOOR);
      tgt_q   <= 4'd0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      door_q  <= 1'b0;
      busy_q  <= 1'b0;
      shift_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      shift_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (head_empty) begin
            state_q <= ST_IDLE;
          end else begin
            tgt_q  <= bus.head_floor;
            busy_q <= 1'b1;
            // Out-of-range entries are dropped straight away so they cannot block the queue.
            if (head_invalid) begin
              state_q <= ST_POP;
              shift_q <= 1'b1;
              err_q   <= 1'b1;
            end else if (bus.head_floor == cur_q) begin
              state_q <= ST_DOOR;
              door_q  <= 1'b1;
            end else if (bus.head_floor > cur_q) begin
              state_q <= ST_MOVE_UP;
              up_q    <= 1'b1;
            end else begin
              state_q <= ST_MOVE_DOWN;
              down_q  <= 1'b1;
            end
          end
        end

        ST_MOVE_UP, ST_MOVE_DOWN: begin
          if (travel_done) begin
            cnt_q <= '0;
            cur_q <= next_floor_d;
            if (next_floor_d == tgt_q) begin
              state_q <= ST_DOOR;
              up_q    <= 1'b0;
              down_q  <= 1'b0;
              door_q  <= 1'b1;
            end else begin
              state_q <= state_q;
            end
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end

        ST_DOOR: begin
          if (bus.door_hold) begin
            cnt_q <= '0;
          end else if (door_done) begin
            cnt_q   <= '0;
            state_q <= ST_POP;
            door_q  <= 1'b0;
            shift_q <= 1'b1;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end

        ST_POP: begin
          tgt_q   <= 4'd0;
          state_q <= ST_SETTLE;
        end

        // One idle-looking cycle so the queue head reflects the pop before re-evaluation.
        ST_SETTLE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          tgt_q   <= 4'd0;
          up_q    <= 1'b0;
          down_q  <= 1'b0;
          door_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.queue_shift   = shift_q;
  assign bus.current_floor = cur_q;
  assign bus.target_floor  = tgt_q;
  assign bus.moving_up     = up_q;
  assign bus.moving_down   = down_q;
  assign bus.door_open     = door_q;
  assign bus.busy          = busy_q;
  assign bus.req_error     = err_q;

endmodule
